// File: rtl/z80_blkcmp_unit_if.sv
// rtl/z80_blkcmp_unit_if.sv - memory read bus between the block-compare unit and its memory
interface z80_blkcmp_unit_if #(
    parameter int ADDR_W = 16
);
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_raddr;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_rd,
        output mem_raddr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd,
        input  mem_raddr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/z80_blkcmp_unit.sv
// rtl/z80_blkcmp_unit.sv - Z80 CPI/CPD/CPIR/CPDR block compare engine
// Optional interrupt abort of repeat ops: define Z80_BLKCMP_INTR_EN.
module z80_blkcmp_unit #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [7:0]          a_in,
    input  logic [7:0]          f_in,
    input  logic [ADDR_W-1:0]   hl_in,
    input  logic [CNT_W-1:0]    bc_in,
    z80_blkcmp_unit_if.master   mem,
    output logic [ADDR_W-1:0]   hl_out,
    output logic [CNT_W-1:0]    bc_out,
    output logic [7:0]          f_out,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    iter_count,
    input  logic                int_req,
    output logic                interrupted
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_a;
    logic [7:0]        r_f;
    logic [7:0]        r_m;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_hl;
    logic [CNT_W-1:0]  r_bc;
    logic [CNT_W-1:0]  r_iter;
    logic              r_intr;

    logic [7:0]        w_r;
    logic              w_z;
    logic              w_h;
    logic [CNT_W-1:0]  w_bc_next;
    logic [ADDR_W-1:0] w_hl_next;
    logic              w_more;
    logic              w_intr;

    assign w_r       = r_a - r_m;
    assign w_z       = (w_r == 8'h00);
    assign w_h       = (r_a[3:0] < r_m[3:0]);
    assign w_bc_next = r_bc - {{(CNT_W-1){1'b0}}, 1'b1};
    assign w_hl_next = r_op[0] ? (r_hl - {{(ADDR_W-1){1'b0}}, 1'b1})
                               : (r_hl + {{(ADDR_W-1){1'b0}}, 1'b1});
    assign w_more    = r_op[1] && (w_bc_next != '0) && !w_z;

`ifdef Z80_BLKCMP_INTR_EN
    assign w_intr = int_req && w_more;
`else
    assign w_intr = int_req & 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = S_READ;
            S_READ: if (mem.mem_ack) w_next = S_EXEC;
            S_EXEC: w_next = (w_more && !w_intr) ? S_READ : S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a    <= '0;
            r_f    <= '0;
            r_m    <= '0;
            r_op   <= '0;
            r_hl   <= '0;
            r_bc   <= '0;
            r_iter <= '0;
            r_intr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_a    <= a_in;
                    r_f    <= f_in;
                    r_hl   <= hl_in;
                    r_bc   <= bc_in;
                    r_op   <= op;
                    r_iter <= '0;
                    r_intr <= 1'b0;
                end
                S_READ: if (mem.mem_ack) r_m <= mem.mem_rdata;
                S_EXEC: begin
                    r_bc   <= w_bc_next;
                    r_hl   <= w_hl_next;
                    r_iter <= r_iter + {{(CNT_W-1){1'b0}}, 1'b1};
                    // F5, F3 and C pass through from the flags latched at start
                    r_f    <= {w_r[7], w_z, r_f[5], w_h, r_f[3], (w_bc_next != '0), 1'b1, r_f[0]};
                    r_intr <= w_intr;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_rd    = (r_state == S_READ);
    assign mem.mem_raddr = r_hl;
    assign hl_out        = r_hl;
    assign bc_out        = r_bc;
    assign f_out         = r_f;
    assign iter_count    = r_iter;
    assign interrupted   = r_intr;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
endmodule

// File: tb/tb_z80_blkcmp_unit.sv
// tb/tb_z80_blkcmp_unit.sv - directed self-checking bench for z80_blkcmp_unit
module tb_z80_blkcmp_unit;
`ifdef Z80_BLKCMP_INTR_EN
    localparam bit INTR_EN = 1'b1;
`else
    localparam bit INTR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [7:0]  a_in = 8'h00;
    logic [7:0]  f_in = 8'h00;
    logic [15:0] hl_in = 16'h0000;
    logic [15:0] bc_in = 16'h0000;
    logic [15:0] hl_out;
    logic [15:0] bc_out;
    logic [7:0]  f_out;
    logic        busy;
    logic        done;
    logic [15:0] iter_count;
    logic        int_req = 1'b0;
    logic        interrupted;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0]  mem_arr [0:65535];

    logic [15:0] m_hl;
    logic [15:0] m_bc;
    logic [7:0]  m_f;
    int          m_iter;
    bit          m_intr;
    int          m_done_cyc;
    logic [15:0] m_addrq [$];

    z80_blkcmp_unit_if #(.ADDR_W(16)) mem_if ();

    z80_blkcmp_unit #(.ADDR_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a_in(a_in), .f_in(f_in), .hl_in(hl_in), .bc_in(bc_in),
        .mem(mem_if),
        .hl_out(hl_out), .bc_out(bc_out), .f_out(f_out),
        .busy(busy), .done(done), .iter_count(iter_count),
        .int_req(int_req), .interrupted(interrupted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: Z80 block compare semantics iterated in plain arithmetic
    task automatic model_op(input logic [7:0] a, input logic [7:0] f, input logic [15:0] hl,
                            input logic [15:0] bc, input logic [1:0] o, input int delay,
                            input int int_iter);
        logic [7:0]  m;
        logic [7:0]  r;
        logic [15:0] h;
        logic [15:0] b;
        bit          more;
        h = hl; b = bc; m_f = f; m_iter = 0; m_intr = 1'b0;
        m_addrq.delete();
        do begin
            m_addrq.push_back(h);
            m = mem_arr[h];
            r = a - m;
            b = b - 16'd1;
            h = o[0] ? h - 16'd1 : h + 16'd1;
            m_iter++;
            m_f = {r[7], (r == 8'h00), f[5], (a[3:0] < m[3:0]), f[3], (b != 16'h0000), 1'b1, f[0]};
            more = o[1] && (b != 16'h0000) && (r != 8'h00);
            if (more && INTR_EN && m_iter == int_iter) begin
                m_intr = 1'b1;
                more = 1'b0;
            end
        end while (more);
        m_hl = h; m_bc = b;
        m_done_cyc = m_iter * (delay + 2) + 1;
    endtask

    // Drives one operation, acts as the memory, and compares against the model every cycle
    task automatic run_op(input logic [7:0] a, input logic [7:0] f, input logic [15:0] hl,
                          input logic [15:0] bc, input logic [1:0] o, input int delay,
                          input int int_iter);
        int n_ack;
        int wcnt;
        bit prev_ack;
        bit fin;
        model_op(a, f, hl, bc, o, delay, int_iter);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; f_in = f; hl_in = hl; bc_in = bc;
        n_ack = 0; wcnt = 0; prev_ack = 1'b0; fin = 1'b0;
        for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                start = 1'b1; hl_in = 16'hDEAD; bc_in = 16'h0001;
            end else begin
                start = 1'b0;
            end
            int_req = prev_ack && (n_ack == int_iter);
            chk("busy_run", busy, 1);
            if (prev_ack) chk("rd_in_exec", mem_if.mem_rd, 0);
            if (mem_if.mem_rd) begin
                chk("raddr", mem_if.mem_raddr, (n_ack < m_addrq.size()) ? m_addrq[n_ack] : 16'hxxxx);
                if (wcnt == delay) begin
                    mem_if.mem_ack = 1'b1;
                    mem_if.mem_rdata = mem_arr[mem_if.mem_raddr];
                    n_ack++;
                    wcnt = 0;
                end else begin
                    mem_if.mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_if.mem_ack = 1'b0;
            end
            prev_ack = mem_if.mem_ack;
            if (done) begin
                fin = 1'b1;
                chk("done_cycle", cyc, m_done_cyc);
                chk("reads", n_ack, m_iter);
                chk("hl", hl_out, m_hl);
                chk("bc", bc_out, m_bc);
                chk("f", f_out, m_f);
                chk("iter", iter_count, m_iter);
                chk("intr", interrupted, m_intr);
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        start = 1'b0; int_req = 1'b0; mem_if.mem_ack = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_hl", hl_out, m_hl);
        chk("idle_intr", interrupted, m_intr);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_hl"}, hl_out, 0);
        chk({tag, "_bc"}, bc_out, 0);
        chk({tag, "_f"}, f_out, 0);
        chk({tag, "_iter"}, iter_count, 0);
        chk({tag, "_raddr"}, mem_if.mem_raddr, 0);
        chk({tag, "_rd"}, mem_if.mem_rd, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_intr"}, interrupted, 0);
    endtask

    initial begin
        mem_if.mem_ack = 1'b0;
        mem_if.mem_rdata = 8'h00;
        for (int i = 0; i < 65536; i++) mem_arr[i] = 8'h80;
        mem_arr[16'h4000] = 8'h10;
        mem_arr[16'h5000] = 8'h1F;
        mem_arr[16'h2002] = 8'h00;
        mem_arr[16'h2001] = 8'h11;
        mem_arr[16'h2000] = 8'h55;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("rst");
        reset = 1'b0;

        // CPI, match on first byte
        run_op(8'h10, 8'h28, 16'h4000, 16'h0003, 2'b00, 0, 0);
        chk("pin_cpi_f", m_f, 8'h6E);
        chk("pin_cpi_hl", m_hl, 16'h4001);
        chk("pin_cpi_bc", m_bc, 16'h0002);
        chk("pin_cpi_cyc", m_done_cyc, 3);

        // CPD with half borrow
        run_op(8'h23, 8'hFF, 16'h5000, 16'h0005, 2'b01, 0, 0);
        chk("pin_cpd_f", m_f, 8'h3F);
        chk("pin_cpd_hl", m_hl, 16'h4FFF);

        // CPDR matching on third byte
        run_op(8'h55, 8'h00, 16'h2002, 16'h0010, 2'b11, 0, 0);
        chk("pin_cpdr_hl", m_hl, 16'h1FFF);
        chk("pin_cpdr_bc", m_bc, 16'h000D);
        chk("pin_cpdr_iter", m_iter, 3);
        chk("pin_cpdr_z", m_f[6], 1);

        // CPIR exhausting BC
        run_op(8'h01, 8'h01, 16'h6000, 16'h0002, 2'b10, 0, 0);
        chk("pin_cpir_f", m_f, 8'h83);
        chk("pin_cpir_bc", m_bc, 16'h0000);
        chk("pin_cpir_iter", m_iter, 2);

        // Wrap cases
        run_op(8'h00, 8'h00, 16'hFFFF, 16'h0001, 2'b00, 0, 0);
        chk("pin_hl_wrap", m_hl, 16'h0000);
        run_op(8'h00, 8'h00, 16'h1234, 16'h0000, 2'b00, 0, 0);
        chk("pin_bc_wrap", m_bc, 16'hFFFF);
        chk("pin_bc_wrap_pv", m_f[2], 1);

        // Wait states on every read
        run_op(8'h01, 8'h00, 16'h7000, 16'h0003, 2'b10, 4, 0);
        chk("pin_wait_cyc", m_done_cyc, 19);

        // Reset while a read is pending
        @(negedge clk);
        start = 1'b1; op = 2'b10; a_in = 8'h01; f_in = 8'hFF; hl_in = 16'h3456; bc_in = 16'h0009;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_rd", mem_if.mem_rd, 1);
        chk("pre_rst_raddr", mem_if.mem_raddr, 16'h3456);
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midrst");
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        run_op(8'h10, 8'h28, 16'h4000, 16'h0003, 2'b00, 0, 0);

        // Interrupt during second EXEC of CPIR
        run_op(8'h01, 8'h00, 16'h3000, 16'h0005, 2'b10, 0, 2);
        if (INTR_EN) begin
            chk("pin_int_bc", m_bc, 16'h0003);
            chk("pin_int_iter", m_iter, 2);
            chk("pin_int_flag", m_intr, 1);
        end else begin
            chk("pin_noint_iter", m_iter, 5);
            chk("pin_noint_flag", m_intr, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
